pio_edge_in: RTL and testbench

PIO_EDGE_IN -- requirements
Module: pio_edge_in

---
 rtl/pio_pkg.sv | 31 +++
 rtl/pio_debounce.sv | 53 +++++
 rtl/pio_edge_in.sv | 144 ++++++++++++++
 tb/tb_pio_edge_in.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// ============================================================================
// pio_pkg -- shared register offsets and edge-type encoding for pio_edge_in
// Revision: 1.0
// ============================================================================
`default_nettype none

package pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_type_e;

    // Out-of-range selectors fall back to rising-edge capture.
    function automatic edge_type_e edge_type_of(input int sel);
        case (sel)
            1:       return EDGE_FALL;
            2:       return EDGE_ANY;
            default: return EDGE_RISE;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/pio_debounce.sv
// ============================================================================
// pio_debounce -- single-bit debouncer: output follows input only after the
// input has differed from it for DEBOUNCE_CYCLES consecutive cycles.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pio_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic din_i,
    output logic dout_o
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             dout_q;
    logic             dout_d;

    // Any cycle where input matches output restarts the count.
    always_comb begin
        cnt_d  = '0;
        dout_d = dout_q;
        if (din_i != dout_q) begin
            if (cnt_q == CNT_LAST) begin
                dout_d = din_i;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            dout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    assign dout_o = dout_q;

endmodule

`default_nettype wire

// File: rtl/pio_edge_in.sv
// ============================================================================
// pio_edge_in -- synchronized parallel input port with per-bit edge capture,
// interrupt mask and W1C edge register. Define PIO_EDGE_IN_DEBOUNCE_EN to add
// per-bit debounce. Revision: 1.0
// ============================================================================
`default_nettype none

module pio_edge_in
    import pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam edge_type_e EDGE_SEL  = edge_type_of(EDGE_TYPE);
    localparam logic [1:0] WARM_DONE = 2'd3;

    if (WIDTH < 1 || WIDTH > 32) begin : g_chk_width
        $error("pio_edge_in: WIDTH must be 1..32");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_chk_debounce
        $error("pio_edge_in: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] dly_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] cap_d;
    logic [1:0]       warm_q;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;
    logic             irq_q;
    logic             irq_d;

    logic [WIDTH-1:0] w_cond;
    logic [WIDTH-1:0] w_det;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_wdata;
    logic             w_wr_en;
    logic             w_unused_wdata;

`ifdef PIO_EDGE_IN_DEBOUNCE_EN
    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        pio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (clk),
            .reset (reset),
            .din_i (sync2_q[i]),
            .dout_o(w_cond[i])
        );
    end
`else
    assign w_cond = sync2_q;
`endif

    // warm_q holds off detection until the delayed copy carries a real
    // post-reset sample, so a level present at reset is never seen as an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            dly_q   <= '0;
            warm_q  <= '0;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
            dly_q   <= w_cond;
            if (warm_q != WARM_DONE) begin
                warm_q <= warm_q + 2'd1;
            end
        end
    end

    always_comb begin
        w_det = '0;
        if (warm_q == WARM_DONE) begin
            case (EDGE_SEL)
                EDGE_FALL: w_det = ~w_cond & dly_q;
                EDGE_ANY:  w_det = w_cond ^ dly_q;
                default:   w_det = w_cond & ~dly_q;
            endcase
        end
    end

    assign w_wr_en        = chipselect & write;
    assign w_wdata        = writedata[WIDTH-1:0];
    assign w_unused_wdata = ^writedata;

    // A fresh edge is OR-ed in after the clear, so it wins over a same-cycle W1C.
    always_comb begin
        mask_d     = mask_q;
        w_clr      = '0;
        readdata_d = '0;
        if (w_wr_en && address == ADDR_MASK) begin
            mask_d = w_wdata;
        end
        if (w_wr_en && address == ADDR_EDGE) begin
            w_clr = w_wdata;
        end
        cap_d = (cap_q & ~w_clr) | w_det;
        irq_d = |(cap_d & mask_d);
        case (address)
            ADDR_DATA: readdata_d = 32'(w_cond);
            ADDR_MASK: readdata_d = 32'(mask_q);
            ADDR_EDGE: readdata_d = 32'(cap_q);
            default:   readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q     <= '0;
            cap_q      <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_pio_edge_in.sv
// ============================================================================
// tb_pio_edge_in -- four pio_edge_in instances (EDGE_TYPE 0..3) on one shared
// bus, checked every cycle against a behavioural model plus directed checks.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pio_edge_in;

    localparam int W    = 5;
    localparam int NDUT = 4;
    localparam int DBC  = 4;

    logic                   clk        = 1'b0;
    logic                   reset      = 1'b1;
    logic [1:0]             address    = 2'd0;
    logic                   chipselect = 1'b0;
    logic                   write      = 1'b0;
    logic [31:0]            writedata  = 32'd0;
    logic [W-1:0]           in_port    = '0;
    logic [NDUT-1:0][31:0]  rd;
    logic [NDUT-1:0]        irq_v;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        pio_edge_in #(
            .WIDTH          (W),
            .EDGE_TYPE      (g),
            .DEBOUNCE_CYCLES(DBC)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .address   (address),
            .chipselect(chipselect),
            .write     (write),
            .writedata (writedata),
            .readdata  (rd[g]),
            .in_port   (in_port),
            .irq       (irq_v[g])
        );
    end

    // ---------------- behavioural model ----------------
    logic [W-1:0] s_hist [2];
    logic [W-1:0] cond_prev;
    logic [W-1:0] db_val;
    int           db_run [W];
    logic [W-1:0] m_mask [NDUT];
    logic [W-1:0] m_cap  [NDUT];
    logic [31:0]  m_rd   [NDUT];
    logic         m_irq  [NDUT];
    int           rel     = 0;
    bit           started = 1'b0;

    always @(posedge clk) begin : p_model
        logic [W-1:0] cond;
        logic [W-1:0] det;
        logic [W-1:0] clr;
        int           et;
        started = 1'b1;
        if (reset) begin
            s_hist[0] = '0;
            s_hist[1] = '0;
            cond_prev = '0;
            db_val    = '0;
            for (int b = 0; b < W; b++) db_run[b] = 0;
            for (int d = 0; d < NDUT; d++) begin
                m_mask[d] = '0;
                m_cap[d]  = '0;
                m_rd[d]   = '0;
                m_irq[d]  = 1'b0;
            end
            rel = 0;
        end else begin
`ifdef PIO_EDGE_IN_DEBOUNCE_EN
            cond = db_val;
`else
            cond = s_hist[1];
`endif
            clr = (chipselect && write && address == 2'd3) ? writedata[W-1:0] : '0;
            for (int d = 0; d < NDUT; d++) begin
                et  = (d > 2) ? 0 : d;
                det = '0;
                if (rel >= 3) begin
                    case (et)
                        1:       det = ~cond & cond_prev;
                        2:       det = cond ^ cond_prev;
                        default: det = cond & ~cond_prev;
                    endcase
                end
                case (address)
                    2'd0:    m_rd[d] = 32'(cond);
                    2'd2:    m_rd[d] = 32'(m_mask[d]);
                    2'd3:    m_rd[d] = 32'(m_cap[d]);
                    default: m_rd[d] = 32'd0;
                endcase
                if (chipselect && write && address == 2'd2) m_mask[d] = writedata[W-1:0];
                m_cap[d] = (m_cap[d] & ~clr) | det;
                m_irq[d] = |(m_cap[d] & m_mask[d]);
            end
`ifdef PIO_EDGE_IN_DEBOUNCE_EN
            for (int b = 0; b < W; b++) begin
                if (s_hist[1][b] != db_val[b]) begin
                    db_run[b]++;
                    if (db_run[b] == DBC) begin
                        db_val[b] = s_hist[1][b];
                        db_run[b] = 0;
                    end
                end else begin
                    db_run[b] = 0;
                end
            end
`endif
            s_hist[1] = s_hist[0];
            s_hist[0] = in_port;
            cond_prev = cond;
            if (rel < 1000) rel++;
        end
    end

    always @(negedge clk) begin : p_compare
        if (started) begin
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if (rd[d] !== m_rd[d]) begin
                    errors++;
                    $display("FAIL model_readdata dut%0d t=%0t: got %h expected %h", d, $time, rd[d], m_rd[d]);
                end
                checks++;
                if (irq_v[d] !== m_irq[d]) begin
                    errors++;
                    $display("FAIL model_irq dut%0d t=%0t: got %b expected %b", d, $time, irq_v[d], m_irq[d]);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write      = 1'b1;
        writedata  = d;
        step(1);
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = 32'd0;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
`ifndef PIO_EDGE_IN_DEBOUNCE_EN
        in_port = 5'h1F;
        step(3);
        check("reset_readdata", rd[0], 32'h0);
        check("reset_irq", 32'(irq_v[0]), 32'h0);
        address = 2'd3;
        reset   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("level_at_reset_cap", rd[0], 32'h0);
            check("level_at_reset_irq", 32'(irq_v[0]), 32'h0);
        end

        in_port = 5'h15;
        address = 2'd0;
        step(3);
        check("data_read_15", rd[0], 32'h15);
        address = 2'd1;
        step(1);
        check("reserved_read", rd[0], 32'h0);

        in_port = 5'h00;
        step(4);
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_write(2'd2, 32'hFFFF_FF01);
        address = 2'd2;
        step(1);
        check("mask_read", rd[0], 32'h01);
        address = 2'd3;
        in_port = 5'h01;
        step(1);
        check("rise_edge1_irq", 32'(irq_v[0]), 32'h0);
        step(1);
        check("rise_edge2_irq", 32'(irq_v[0]), 32'h0);
        step(1);
        check("rise_edge3_irq", 32'(irq_v[0]), 32'h1);
        step(1);
        check("rise_cap_read", rd[0], 32'h01);
        bus_write(2'd3, 32'h1);
        check("w1c_irq_low", 32'(irq_v[0]), 32'h0);
        address = 2'd3;
        step(1);
        check("w1c_cap_read", rd[0], 32'h0);

        in_port = 5'h05;
        step(4);
        bus_write(2'd3, 32'h4);
        address = 2'd3;
        step(1);
        check("bit2_cleared", rd[0], 32'h0);
        in_port = 5'h01;
        step(4);
        in_port = 5'h05;
        step(2);
        bus_write(2'd3, 32'h4);
        address = 2'd3;
        step(1);
        check("edge_beats_w1c", rd[0], 32'h4);
        check("edge_beats_w1c_irq", 32'(irq_v[0]), 32'h0);

        step(3);
        bus_write(2'd2, 32'h0);
        bus_write(2'd3, 32'hFFFF_FFFF);
        address = 2'd3;
        in_port = 5'h07;
        step(3);
        in_port = 5'h05;
        step(4);
        check("any_edge_cap", rd[2], 32'h2);
        check("any_edge_masked_irq", 32'(irq_v[2]), 32'h0);
        bus_write(2'd2, 32'h2);
        check("any_edge_unmasked_irq", 32'(irq_v[2]), 32'h1);

        bus_write(2'd3, 32'hFFFF_FFFF);
        in_port = 5'h00;
        step(4);
        bus_write(2'd3, 32'hFFFF_FFFF);
        address = 2'd3;
        in_port = 5'h1F;
        step(2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(8);
        check("midreset_abort_cap", rd[0], 32'h0);
        check("midreset_abort_irq", 32'(irq_v[0]), 32'h0);
`else
        in_port = 5'h00;
        step(3);
        check("reset_readdata", rd[0], 32'h0);
        reset = 1'b0;
        step(5);
        bus_write(2'd2, 32'h1);
        address = 2'd3;
        in_port = 5'h01;
        step(3);
        in_port = 5'h00;
        step(12);
        check("db_short_pulse_cap", rd[0], 32'h0);
        check("db_short_pulse_irq", 32'(irq_v[0]), 32'h0);
        in_port = 5'h01;
        step(6);
        in_port = 5'h00;
        step(14);
        check("db_long_pulse_cap", rd[0], 32'h1);
        check("db_long_pulse_irq", 32'(irq_v[0]), 32'h1);
`endif
        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
